// File: rtl/cricket_pkg.sv
// Shared types and widths for the cricket game-state engine.
package cricket_pkg;

    typedef enum logic [1:0] {
        ST_INN1  = 2'd0,
        ST_BREAK = 2'd1,
        ST_INN2  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [2:0] OUTCOME_WICKET = 3'd7;

    localparam int RUNS_W = 8;
    localparam int WKT_W  = 4;
    localparam int BALL_W = 6;

    // Runs stick at the top of the display range rather than wrapping.
    function automatic logic [RUNS_W-1:0] sat_add_runs(input logic [RUNS_W-1:0] runs,
                                                       input logic [2:0]        outcome);
        logic [RUNS_W:0] sum;
        sum = {1'b0, runs} + {{(RUNS_W-2){1'b0}}, outcome};
        return sum[RUNS_W] ? '1 : sum[RUNS_W-1:0];
    endfunction

endpackage

// File: rtl/cricket_scorekeeper_innings_tally.sv
// Runs/wickets/balls counters for one innings; reused for both innings via clear_i.
module innings_tally
    import cricket_pkg::*;
#(
    parameter int BALLS_PER_INNING = 12,
    parameter int MAX_WICKETS      = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              ball_valid_i,
    input  logic [2:0]        ball_outcome_i,
    output logic [RUNS_W-1:0] runs_o,
    output logic [WKT_W-1:0]  wickets_o,
    output logic [BALL_W-1:0] balls_o,
    output logic [RUNS_W-1:0] runs_next_o,
    output logic              innings_end_o
);

    logic [RUNS_W-1:0] runs_q,  runs_d;
    logic [WKT_W-1:0]  wkts_q,  wkts_d;
    logic [BALL_W-1:0] balls_q, balls_d;

    always_comb begin
        runs_d  = runs_q;
        wkts_d  = wkts_q;
        balls_d = balls_q;
        if (clear_i) begin
            runs_d  = '0;
            wkts_d  = '0;
            balls_d = '0;
        end else if (ball_valid_i) begin
            if (ball_outcome_i == OUTCOME_WICKET) begin
                wkts_d = wkts_q + WKT_W'(1);
            end else begin
                runs_d = sat_add_runs(runs_q, ball_outcome_i);
            end
            balls_d = balls_q + BALL_W'(1);
        end
    end

    // Post-ball view lets the controller change state on the same edge the ball lands.
    assign runs_next_o   = runs_d;
    assign innings_end_o = (wkts_d == WKT_W'(MAX_WICKETS)) ||
                           (balls_d == BALL_W'(BALLS_PER_INNING));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            runs_q  <= '0;
            wkts_q  <= '0;
            balls_q <= '0;
        end else begin
            runs_q  <= runs_d;
            wkts_q  <= wkts_d;
            balls_q <= balls_d;
        end
    end

    assign runs_o    = runs_q;
    assign wickets_o = wkts_q;
    assign balls_o   = balls_q;

endmodule

// File: rtl/cricket_scorekeeper.sv
// Two-innings cricket game controller: innings sequencing, target latch and result.
module cricket_scorekeeper
    import cricket_pkg::*;
#(
    parameter int BALLS_PER_INNING = 12,
    parameter int MAX_WICKETS      = 10
) (
    input  logic              clk_fpga,
    input  logic              reset,
    input  logic              ball_valid,
    input  logic [2:0]        ball_outcome,
    input  logic              next_inning,
    input  logic              new_game,
    output logic [RUNS_W-1:0] binaryRuns,
    output logic [WKT_W-1:0]  binaryWickets,
    output logic [BALL_W-1:0] balls_bowled,
    output logic              inningOver,
    output logic              gameOver,
    output logic              winner,
    output logic              tie
);

    state_e            state_q;
    logic [RUNS_W-1:0] target_q;
    logic              inning_over_q, game_over_q, winner_q, tie_q;

    logic              in_play, count_en, tally_clear, innings_end, chase_won;
    logic [RUNS_W-1:0] runs_next;

    assign in_play     = (state_q == ST_INN1) || (state_q == ST_INN2);
    assign count_en    = ball_valid && in_play;
    assign tally_clear = ((state_q == ST_BREAK) && next_inning) ||
                         ((state_q == ST_DONE)  && new_game);
    assign chase_won   = runs_next > target_q;

    innings_tally #(
        .BALLS_PER_INNING (BALLS_PER_INNING),
        .MAX_WICKETS      (MAX_WICKETS)
    ) u_tally (
        .clk_i          (clk_fpga),
        .rst_i          (reset),
        .clear_i        (tally_clear),
        .ball_valid_i   (count_en),
        .ball_outcome_i (ball_outcome),
        .runs_o         (binaryRuns),
        .wickets_o      (binaryWickets),
        .balls_o        (balls_bowled),
        .runs_next_o    (runs_next),
        .innings_end_o  (innings_end)
    );

    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            state_q       <= ST_INN1;
            target_q      <= '0;
            inning_over_q <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
            tie_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_INN1: begin
                    if (count_en && innings_end) begin
                        state_q       <= ST_BREAK;
                        target_q      <= runs_next;
                        inning_over_q <= 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (next_inning) begin
                        state_q       <= ST_INN2;
                        inning_over_q <= 1'b0;
                    end
                end
                ST_INN2: begin
                    // A chase win on the last ball still counts as a win, not exhaustion.
                    if (count_en && (chase_won || innings_end)) begin
                        state_q     <= ST_DONE;
                        game_over_q <= 1'b1;
                        winner_q    <= chase_won;
                        tie_q       <= !chase_won && (runs_next == target_q);
                    end
                end
                ST_DONE: begin
                    if (new_game) begin
                        state_q     <= ST_INN1;
                        target_q    <= '0;
                        game_over_q <= 1'b0;
                        winner_q    <= 1'b0;
                        tie_q       <= 1'b0;
                    end
                end
                default: state_q <= ST_INN1;
            endcase
        end
    end

    assign inningOver = inning_over_q;
    assign gameOver   = game_over_q;
    assign winner     = winner_q;
    assign tie        = tie_q;

endmodule

// File: tb/tb_cricket_scorekeeper.sv
// Self-checking bench for cricket_scorekeeper: directed scenarios plus randomized play vs a game model.
module tb_cricket_scorekeeper;

    localparam int BPI     = 12;
    localparam int MAXW    = 10;
    localparam int SAT_BPI = 63;

    logic clk_fpga = 1'b0;
    always #5 clk_fpga = ~clk_fpga;

    logic       reset, ball_valid, next_inning, new_game;
    logic [2:0] ball_outcome;
    logic [7:0] binaryRuns;
    logic [3:0] binaryWickets;
    logic [5:0] balls_bowled;
    logic       inningOver, gameOver, winner, tie;

    logic       s_reset, s_valid, s_next, s_new;
    logic [2:0] s_outcome;
    logic [7:0] s_runs;
    logic [3:0] s_wkts;
    logic [5:0] s_balls;
    logic       s_inning_over, s_game_over, s_winner, s_tie;

    int n_vec = 0;
    int n_err = 0;

    int m_phase, m_runs, m_wkts, m_balls, m_target;
    bit m_winner, m_tie;

    cricket_scorekeeper #(.BALLS_PER_INNING(BPI), .MAX_WICKETS(MAXW)) dut (
        .clk_fpga      (clk_fpga),
        .reset         (reset),
        .ball_valid    (ball_valid),
        .ball_outcome  (ball_outcome),
        .next_inning   (next_inning),
        .new_game      (new_game),
        .binaryRuns    (binaryRuns),
        .binaryWickets (binaryWickets),
        .balls_bowled  (balls_bowled),
        .inningOver    (inningOver),
        .gameOver      (gameOver),
        .winner        (winner),
        .tie           (tie)
    );

    cricket_scorekeeper #(.BALLS_PER_INNING(SAT_BPI), .MAX_WICKETS(MAXW)) dut_sat (
        .clk_fpga      (clk_fpga),
        .reset         (s_reset),
        .ball_valid    (s_valid),
        .ball_outcome  (s_outcome),
        .next_inning   (s_next),
        .new_game      (s_new),
        .binaryRuns    (s_runs),
        .binaryWickets (s_wkts),
        .balls_bowled  (s_balls),
        .inningOver    (s_inning_over),
        .gameOver      (s_game_over),
        .winner        (s_winner),
        .tie           (s_tie)
    );

    function automatic logic [21:0] dut_pack();
        return {binaryRuns, binaryWickets, balls_bowled, inningOver, gameOver, winner, tie};
    endfunction

    // phase: 0 = first innings, 1 = break, 2 = chase, 3 = game over
    function automatic logic [21:0] model_pack();
        return {8'(m_runs), 4'(m_wkts), 6'(m_balls), (m_phase == 1), (m_phase == 3), m_winner, m_tie};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_runs = 0; m_wkts = 0; m_balls = 0; m_target = 0;
        m_winner = 0; m_tie = 0;
    endtask

    task automatic model_cycle(input bit bv, input int bo, input bit ni, input bit ng);
        case (m_phase)
            0, 2: if (bv) begin
                if (bo == 7) m_wkts++;
                else m_runs = (m_runs + bo > 255) ? 255 : m_runs + bo;
                m_balls++;
                if (m_phase == 0) begin
                    if (m_wkts == MAXW || m_balls == BPI) begin
                        m_phase = 1;
                        m_target = m_runs;
                    end
                end else if (m_runs > m_target || m_wkts == MAXW || m_balls == BPI) begin
                    m_winner = (m_runs > m_target);
                    m_tie    = (m_runs == m_target);
                    m_phase  = 3;
                end
            end
            1: if (ni) begin
                m_runs = 0; m_wkts = 0; m_balls = 0; m_phase = 2;
            end
            3: if (ng) model_reset();
            default: ;
        endcase
    endtask

    task automatic cycle(input bit bv, input logic [2:0] bo, input bit ni, input bit ng);
        ball_valid = bv; ball_outcome = bo; next_inning = ni; new_game = ng;
        @(negedge clk_fpga);
        model_cycle(bv, int'(bo), ni, ng);
        ball_valid = 0; next_inning = 0; new_game = 0;
    endtask

    task automatic s_ball(input logic [2:0] o);
        s_valid = 1; s_outcome = o;
        @(negedge clk_fpga);
        s_valid = 0;
    endtask

    task automatic test_reset();
        logic [2:0] seq [9] = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd1, 3'd7, 3'd7};
        reset = 1;
        repeat (2) @(negedge clk_fpga);
        reset = 0;
        model_reset();
        n_vec++;
        if (dut_pack() !== 22'd0) begin
            n_err++; $display("FAIL reset_state got %h exp 0", dut_pack());
        end
        foreach (seq[i]) cycle(1, seq[i], 0, 0);
        n_vec++;
        if ({binaryRuns, binaryWickets} !== {8'd37, 4'd2}) begin
            n_err++; $display("FAIL pre_reset_tally got %0d/%0d exp 37/2", binaryRuns, binaryWickets);
        end
        ball_valid = 1; ball_outcome = 3'd5;
        #2 reset = 1;
        @(negedge clk_fpga);
        ball_valid = 0;
        n_vec++;
        if (dut_pack() !== 22'd0) begin
            n_err++; $display("FAIL reset_mid_ball got %h exp 0", dut_pack());
        end
        reset = 0;
        model_reset();
        @(negedge clk_fpga);
        n_vec++;
        if (dut_pack() !== 22'd0) begin
            n_err++; $display("FAIL reset_release got %h exp 0", dut_pack());
        end
    endtask

    task automatic test_inn1_full();
        repeat (11) cycle(1, 3'd4, 0, 0);
        n_vec++;
        if ({inningOver, binaryRuns} !== {1'b0, 8'd44}) begin
            n_err++; $display("FAIL inn1_11th got io=%0d runs=%0d exp io=0 runs=44", inningOver, binaryRuns);
        end
        cycle(1, 3'd4, 0, 0);
        n_vec++;
        if ({binaryRuns, balls_bowled, inningOver} !== {8'd48, 6'd12, 1'b1}) begin
            n_err++; $display("FAIL inn1_end got runs=%0d balls=%0d io=%0d exp 48/12/1",
                              binaryRuns, balls_bowled, inningOver);
        end
        cycle(1, 3'd4, 0, 0);
        cycle(0, 3'd0, 0, 1);
        n_vec++;
        if ({binaryRuns, balls_bowled, inningOver, gameOver} !== {8'd48, 6'd12, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL break_ignore got runs=%0d balls=%0d io=%0d go=%0d exp 48/12/1/0",
                              binaryRuns, balls_bowled, inningOver, gameOver);
        end
    endtask

    task automatic test_chase_win();
        cycle(1, 3'd6, 1, 0);
        n_vec++;
        if (dut_pack() !== 22'd0) begin
            n_err++; $display("FAIL next_inning_clear got %h exp 0", dut_pack());
        end
        repeat (8) cycle(1, 3'd6, 0, 0);
        n_vec++;
        if ({gameOver, binaryRuns} !== {1'b0, 8'd48}) begin
            n_err++; $display("FAIL chase_level got go=%0d runs=%0d exp 0/48", gameOver, binaryRuns);
        end
        cycle(1, 3'd6, 0, 0);
        n_vec++;
        if ({gameOver, winner, tie, balls_bowled, binaryRuns} !== {1'b1, 1'b1, 1'b0, 6'd9, 8'd54}) begin
            n_err++; $display("FAIL chase_win got go=%0d w=%0d t=%0d balls=%0d runs=%0d exp 1/1/0/9/54",
                              gameOver, winner, tie, balls_bowled, binaryRuns);
        end
        cycle(1, 3'd6, 1, 0);
        n_vec++;
        if (dut_pack() !== model_pack() || binaryRuns !== 8'd54) begin
            n_err++; $display("FAIL done_frozen got %h exp %h", dut_pack(), model_pack());
        end
    endtask

    task automatic test_wicket_loss();
        cycle(0, 3'd0, 0, 1);
        n_vec++;
        if (dut_pack() !== 22'd0) begin
            n_err++; $display("FAIL new_game_clear got %h exp 0", dut_pack());
        end
        repeat (12) cycle(1, 3'd4, 0, 0);
        cycle(0, 3'd0, 1, 0);
        repeat (9) cycle(1, 3'd7, 0, 0);
        n_vec++;
        if ({gameOver, binaryWickets} !== {1'b0, 4'd9}) begin
            n_err++; $display("FAIL wkt_9 got go=%0d wk=%0d exp 0/9", gameOver, binaryWickets);
        end
        cycle(1, 3'd7, 0, 0);
        n_vec++;
        if ({gameOver, winner, tie, binaryWickets} !== {1'b1, 1'b0, 1'b0, 4'd10}) begin
            n_err++; $display("FAIL all_out got go=%0d w=%0d t=%0d wk=%0d exp 1/0/0/10",
                              gameOver, winner, tie, binaryWickets);
        end
    endtask

    task automatic test_tie();
        cycle(0, 3'd0, 0, 1);
        repeat (10) cycle(1, 3'd2, 0, 0);
        repeat (2) cycle(1, 3'd0, 0, 0);
        n_vec++;
        if ({inningOver, binaryRuns} !== {1'b1, 8'd20}) begin
            n_err++; $display("FAIL tie_target got io=%0d runs=%0d exp 1/20", inningOver, binaryRuns);
        end
        cycle(0, 3'd0, 1, 0);
        repeat (10) cycle(1, 3'd2, 0, 0);
        repeat (2) cycle(1, 3'd0, 0, 0);
        n_vec++;
        if ({gameOver, tie, winner, balls_bowled, binaryRuns} !== {1'b1, 1'b1, 1'b0, 6'd12, 8'd20}) begin
            n_err++; $display("FAIL tie_result got go=%0d t=%0d w=%0d balls=%0d runs=%0d exp 1/1/0/12/20",
                              gameOver, tie, winner, balls_bowled, binaryRuns);
        end
        cycle(0, 3'd0, 0, 1);
        cycle(1, 3'd3, 0, 0);
        cycle(0, 3'd0, 0, 1);
        n_vec++;
        if ({binaryRuns, balls_bowled, gameOver, inningOver} !== {8'd3, 6'd1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL new_game_in_inn1 got runs=%0d balls=%0d exp 3/1", binaryRuns, balls_bowled);
        end
    endtask

    task automatic test_saturation();
        s_reset = 0;
        repeat (42) s_ball(3'd6);
        n_vec++;
        if (s_runs !== 8'd252) begin
            n_err++; $display("FAIL sat_252 got %0d exp 252", s_runs);
        end
        s_ball(3'd6);
        n_vec++;
        if (s_runs !== 8'd255) begin
            n_err++; $display("FAIL sat_clip got %0d exp 255", s_runs);
        end
        s_ball(3'd5);
        repeat (SAT_BPI - 44) s_ball(3'd0);
        n_vec++;
        if ({s_inning_over, s_runs, s_balls} !== {1'b1, 8'd255, 6'd63}) begin
            n_err++; $display("FAIL sat_inn1_end got io=%0d runs=%0d balls=%0d exp 1/255/63",
                              s_inning_over, s_runs, s_balls);
        end
        s_next = 1;
        @(negedge clk_fpga);
        s_next = 0;
        repeat (SAT_BPI - 1) s_ball(3'd6);
        n_vec++;
        if ({s_game_over, s_runs} !== {1'b0, 8'd255}) begin
            n_err++; $display("FAIL sat_no_win got go=%0d runs=%0d exp 0/255", s_game_over, s_runs);
        end
        s_ball(3'd6);
        n_vec++;
        if ({s_game_over, s_tie, s_winner} !== {1'b1, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL sat_tie got go=%0d t=%0d w=%0d exp 1/1/0", s_game_over, s_tie, s_winner);
        end
    endtask

    task automatic test_random();
        reset = 1;
        @(negedge clk_fpga);
        reset = 0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic       bv, ni, ng;
            logic [2:0] bo;
            bv = ($urandom_range(0, 9) < 7);
            bo = 3'($urandom_range(0, 7));
            ni = ($urandom_range(0, 7) == 0);
            ng = ($urandom_range(0, 11) == 0);
            cycle(bv, bo, ni, ng);
            n_vec++;
            if (dut_pack() !== model_pack()) begin
                n_err++; $display("FAIL random_cycle_%0d got %h exp %h", c, dut_pack(), model_pack());
            end
        end
    endtask

    initial begin
        reset = 1; ball_valid = 0; ball_outcome = 0; next_inning = 0; new_game = 0;
        s_reset = 1; s_valid = 0; s_outcome = 0; s_next = 0; s_new = 0;
        model_reset();
        @(negedge clk_fpga);
        test_reset();
        test_inn1_full();
        test_chase_win();
        test_wicket_loss();
        test_tie();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
